sa_feeder: RTL and testbench

Operand sequencer for the 4x4 systolic array (SA). It holds matrices A and B (4x4, 10-bit unsigned) in a local 32-entry register file, then on command drives the SA's a1..a4/b1..b4 inputs with the diagonally skewed wavefront the array expects. It also issues the SA accumulator-clear pulse and waits out the array drain latency. It is the transmitting end of the SA operand interface and replaces hand-written stimulus sequencing.

---
 rtl/sa_feeder.sv | 145 ++++++++++++++
 tb/tb_sa_feeder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - skewed operand sequencer for the 4x4 systolic array
// Optional SA_FEEDER_AUTOSTART_EN: an idle write to address 31 also launches a run.
module sa_feeder #(
  parameter int DW        = 10,
  parameter int DRAIN_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [4:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sa_reset,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] a3,
  output logic [DW-1:0] a4,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] b4
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    k;
  logic [3:0]    dcnt;
  logic [DW-1:0] rf [32];
  logic [DW-1:0] a_q [4];
  logic [DW-1:0] b_q [4];
  logic [DW-1:0] a_nx [4];
  logic [DW-1:0] b_nx [4];
  logic [2:0]    feed_k;
  logic          wr_ok;
  logic          launch;

  assign a1 = a_q[0];
  assign a2 = a_q[1];
  assign a3 = a_q[2];
  assign a4 = a_q[3];
  assign b1 = b_q[0];
  assign b2 = b_q[1];
  assign b3 = b_q[2];
  assign b4 = b_q[3];

  always_comb begin
    wr_ok  = wr_en && (state == S_IDLE);
    launch = 1'b0;
    if (state == S_IDLE) begin
`ifdef SA_FEEDER_AUTOSTART_EN
      launch = start || (wr_en && (wr_addr == 5'd31));
`else
      launch = start;
`endif
    end
  end

  // Wavefront slot that the next edge will present; stream i lags stream 0 by i cycles.
  always_comb begin
    feed_k = (state == S_CLR) ? 3'd0 : k + 3'd1;
    for (int i = 0; i < 4; i++) begin
      a_nx[i] = '0;
      b_nx[i] = '0;
      if (feed_k >= 3'(i) && feed_k <= 3'(i + 3)) begin
        a_nx[i] = rf[{1'b0, 2'(i), 2'(feed_k - 3'(i))}];
        b_nx[i] = rf[{1'b1, 2'(i), 2'(feed_k - 3'(i))}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      dcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sa_reset <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      sa_reset <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      if (wr_ok) rf[wr_addr] <= wr_data;
      case (state)
        S_IDLE: begin
          if (launch) begin
            state    <= S_CLR;
            sa_reset <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_CLR: begin
          state <= S_FEED;
          k     <= '0;
          a_q   <= a_nx;
          b_q   <= b_nx;
        end
        S_FEED: begin
          if (k == 3'd6) begin
            state <= S_DRAIN;
            dcnt  <= 4'd1;
          end else begin
            k   <= k + 3'd1;
            a_q <= a_nx;
            b_q <= b_nx;
          end
        end
        S_DRAIN: begin
          if (dcnt == 4'(DRAIN_CYC)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          k     <= '0;
          dcnt  <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - randomized self-checking bench for sa_feeder
// Reference: per-run timeline model plus a behavioural 4x4 systolic array.
module tb_sa_feeder;
  localparam int DW = 10;
  localparam int DRAIN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic start = 1'b0;
  logic busy, done, sa_reset;
  logic [DW-1:0] a1, a2, a3, a4, b1, b2, b3, b4;

  int tests = 0;
  int fails = 0;

  sa_feeder #(.DW(DW), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .sa_reset(sa_reset),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3), .b4(b4)
  );

  always #5 clk = ~clk;

  // Timeline model: run_t = edges since the accepted start, -1 when idle.
  int mem [32];
  int run_t = -1;
  bit chk_en = 0;
  int e_a [4];
  int e_b [4];
  bit e_busy, e_done, e_sar;

  always @(posedge clk) begin
    bit go;
    if (reset) begin
      run_t = -1;
      for (int i = 0; i < 32; i++) mem[i] = 0;
      chk_en = 1;
    end else if (run_t < 0) begin
      go = start;
`ifdef SA_FEEDER_AUTOSTART_EN
      if (wr_en && wr_addr == 5'd31) go = 1;
`endif
      if (wr_en) mem[wr_addr] = int'(wr_data);
      if (go) run_t = 0;
    end else begin
      run_t++;
      if (run_t == 9 + DRAIN) run_t = -1;
    end
    e_busy = (run_t >= 0);
    e_sar  = (run_t == 0);
    e_done = (run_t == 8 + DRAIN);
    for (int i = 0; i < 4; i++) begin
      int idx;
      e_a[i] = 0;
      e_b[i] = 0;
      idx = (run_t - 1) - i;
      if (run_t >= 1 && run_t <= 7 && idx >= 0 && idx <= 3) begin
        e_a[i] = mem[4*i + idx];
        e_b[i] = mem[16 + 4*i + idx];
      end
    end
  end

  // Behavioural SA: PE(i,j) sees a_i delayed j cycles and b_j delayed i cycles.
  int hist_a [4][4];
  int hist_b [4][4];
  int acc [4][4];
  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        hist_a[i][j] = 0; hist_b[i][j] = 0; acc[i][j] = 0;
      end
  end

  always @(negedge clk) begin
    int da [4];
    int db [4];
    bit bad;
    da[0] = int'(a1); da[1] = int'(a2); da[2] = int'(a3); da[3] = int'(a4);
    db[0] = int'(b1); db[1] = int'(b2); db[2] = int'(b3); db[3] = int'(b4);
    if (chk_en) begin
      bad = $isunknown({busy, done, sa_reset, a1, a2, a3, a4, b1, b2, b3, b4}) ||
            busy !== e_busy || done !== e_done || sa_reset !== e_sar;
      for (int i = 0; i < 4; i++) if (da[i] != e_a[i] || db[i] != e_b[i]) bad = 1;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL cycle_check t=%0t busy/done/sar got %0b%0b%0b want %0b%0b%0b a got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d b got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                 $time, busy, done, sa_reset, e_busy, e_done, e_sar,
                 da[0], da[1], da[2], da[3], e_a[0], e_a[1], e_a[2], e_a[3],
                 db[0], db[1], db[2], db[3], e_b[0], e_b[1], e_b[2], e_b[3]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int d = 3; d > 0; d--) begin
        hist_a[i][d] = hist_a[i][d-1];
        hist_b[i][d] = hist_b[i][d-1];
      end
      hist_a[i][0] = da[i];
      hist_b[i][0] = db[i];
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (sa_reset === 1'b1) acc[i][j] = 0;
        else acc[i][j] += hist_a[i][j] * hist_b[j][i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = 5'(a); wr_data = DW'(d);
    tick();
    wr_en = 0;
  endtask

  task automatic start_pulse();
    start = 1;
    tick();
    start = 0;
  endtask

  // Writes 0..30, then address 31 together with start; returns just after E0.
  task automatic load_and_run(input int vals [32]);
    for (int a = 0; a < 31; a++) wr(a, vals[a]);
    wr_en = 1; wr_addr = 5'd31; wr_data = DW'(vals[31]); start = 1;
    tick();
    wr_en = 0; start = 0;
  endtask

  task automatic wait_done(input string nm, input bit noise);
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (noise) begin
        wr_en = 1'($urandom_range(0, 1));
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = DW'($urandom_range(0, 1023));
        start = ($urandom_range(0, 3) == 0);
      end
      tick();
      if (done === 1'b1) seen = 1;
    end
    wr_en = 0; start = 0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end
    tick();
  endtask

  task automatic check_sa(input string nm);
    int bad = 0;
    int ga = 0;
    int ge = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int e = 0;
        for (int k = 0; k < 4; k++) e += mem[4*i + k] * mem[16 + 4*j + k];
        if (acc[i][j] != e) begin
          if (bad == 0) begin ga = acc[i][j]; ge = e; end
          bad++;
        end
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d cells wrong, first got %0d expected %0d", nm, bad, ga, ge);
    end
  endtask

  task automatic check_max(input string nm);
    int bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc[i][j] != 4186116) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    int vals [32];
    tick(); tick();
    reset = 0;
    chk("reset_busy", busy, 0);
    chk("reset_a1", a1, 0);
    repeat (20) tick();
    chk("reset_done", done, 0);

    // Identity A, B[j][k] = 16+4j+k
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        vals[4*i + k] = (i == k) ? 1 : 0;
        vals[16 + 4*i + k] = 16 + 4*i + k;
      end
    load_and_run(vals);
    chk("ident_sa_reset", sa_reset, 1);
    chk("ident_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ident_b1", b1, 16 + k);
    end
    repeat (8) tick();
    chk("ident_done_e12", done, 1);
    tick();
    chk("ident_idle_e13", busy, 0);
    check_sa("ident_sa");
    chk("ident_c13", acc[1][3], 29);
    chk("ident_c00", acc[0][0], 16);

    // Skew: A[i][k] = 4i+k+1
    for (int i = 0; i < 16; i++) vals[i] = i + 1;
    load_and_run(vals);
    repeat (4) tick();
    chk("skew_e4_a1", a1, 4);
    chk("skew_e4_a2", a2, 7);
    chk("skew_e4_a3", a3, 10);
    chk("skew_e4_a4", a4, 13);
    repeat (3) tick();
    chk("skew_e7_a4", a4, 16);
    chk("skew_e7_a123", int'(a1) + int'(a2) + int'(a3), 0);
    wait_done("skew", 0);
    check_sa("skew_sa");

    // Busy protection
    start_pulse();
    tick(); tick();
    wr_en = 1; wr_addr = 5'd0; wr_data = DW'(1023); start = 1;
    tick();
    wr_en = 0; start = 0;
    chk("busy_e3_a1", a1, 3);
    wait_done("busy", 0);
    repeat (3) begin
      tick();
      chk("busy_no_rerun", busy, 0);
    end
    start_pulse();
    tick();
    chk("busy_old_a00", a1, 1);
    wait_done("busy2", 0);
    check_sa("busy_sa");

    // Reset mid-run
    start_pulse();
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_outs", int'({busy, done, sa_reset}) + int'(a1 | a2 | a3 | a4 | b1 | b2 | b3 | b4), 0);
    repeat (20) tick();
    start_pulse();
    tick(); tick();
    chk("rst_rf_a1", a1, 0);
    chk("rst_rf_b1", b1, 0);
    wait_done("rst", 0);
    check_sa("rst_sa");

    // Max values, two runs back to back
    for (int a = 0; a < 31; a++) wr(a, 1023);
`ifdef SA_FEEDER_AUTOSTART_EN
    wr(31, 1023);
`else
    wr(31, 1023);
    start_pulse();
`endif
    chk("max_sa_reset", sa_reset, 1);
    wait_done("max1", 0);
    check_max("max_run1");
    start_pulse();
    wait_done("max2", 0);
    check_max("max_run2");

    // Randomized runs with write/start noise while busy
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 32; a++) vals[a] = $urandom_range(0, 1023);
      load_and_run(vals);
      wait_done("rand", 1);
      check_sa("rand_sa");
      repeat (2) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
